sal_dfi_cmd_decoder: RTL and testbench

//  DRAM-side receiver for the DFI control bus driven by the controller's command encoder.

---
 rtl/sal_dfi_cmd_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_sal_dfi_cmd_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sal_dfi_cmd_decoder.sv
// DRAM-side DFI command receiver: registers the control bus, decodes commands,
// tracks per-bank state and flags tRCD/tRP/tRFC and bank-state violations.
module sal_dfi_cmd_decoder #(
  parameter int unsigned BA_WIDTH   = 3,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned CS_WIDTH   = 1,
  parameter int unsigned T_RCD      = 10,
  parameter int unsigned T_RP       = 10,
  parameter int unsigned T_RFC      = 52
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cke,
  input  logic [CS_WIDTH-1:0]   cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [BA_WIDTH-1:0]   ba,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  cmd_valid,
  output logic [2:0]            cmd_type,
  output logic [BA_WIDTH-1:0]   cmd_ba,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [(2**BA_WIDTH)-1:0] bank_open,
  output logic                  err_valid,
  output logic [2:0]            err_code,
  output logic                  err_sticky
);

  localparam int unsigned NUM_BANKS  = 2 ** BA_WIDTH;
  localparam int unsigned T_BANK_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned CNT_W      = $clog2(T_BANK_MAX);
  localparam int unsigned RFC_W      = $clog2(T_RFC);

  localparam logic [2:0] CMD_ACT  = 3'd0;
  localparam logic [2:0] CMD_RD   = 3'd1;
  localparam logic [2:0] CMD_WR   = 3'd2;
  localparam logic [2:0] CMD_PRE  = 3'd3;
  localparam logic [2:0] CMD_PREA = 3'd4;
  localparam logic [2:0] CMD_REF  = 3'd5;
  localparam logic [2:0] CMD_UNS  = 3'd7;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_BANK_BUSY  = 3'd1;
  localparam logic [2:0] ERR_NOT_ACTIVE = 3'd2;
  localparam logic [2:0] ERR_REF_IDLE   = 3'd3;
  localparam logic [2:0] ERR_IN_RFC     = 3'd4;
  localparam logic [2:0] ERR_UNSUP      = 3'd5;
  localparam logic [2:0] ERR_CKE_LOW    = 3'd6;

  typedef enum logic [1:0] {IDLE, ACTIVATING, ACTIVE, PRECHARGING} bank_state_e;

  logic                  cke_q, cs_q, ras_q, cas_q, we_q;
  logic [BA_WIDTH-1:0]   ba_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  bank_state_e state_q [NUM_BANKS];
  bank_state_e state_d [NUM_BANKS];
  bank_state_e eff     [NUM_BANKS];
  logic [CNT_W-1:0] cnt_q [NUM_BANKS];
  logic [CNT_W-1:0] cnt_d [NUM_BANKS];
  logic [RFC_W-1:0] rfc_q, rfc_d;

  logic is_act, is_rd, is_wr, is_pre, is_prea, is_ref, is_uns, dec_valid, legal, any_busy;
  logic [2:0] dec_type, code_d;
  logic [NUM_BANKS-1:0] open_d;

  // Stage 1: capture the DFI bus; reset leaves a DESELECT in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cke_q  <= 1'b1;
      cs_q   <= 1'b1;
      ras_q  <= 1'b1;
      cas_q  <= 1'b1;
      we_q   <= 1'b1;
      ba_q   <= '0;
      addr_q <= '0;
    end else begin
      cke_q  <= cke;
      cs_q   <= cs_n[0];
      ras_q  <= ras_n;
      cas_q  <= cas_n;
      we_q   <= we_n;
      ba_q   <= ba;
      addr_q <= addr;
    end
  end

  always_comb begin
    is_act  = 1'b0;
    is_rd   = 1'b0;
    is_wr   = 1'b0;
    is_pre  = 1'b0;
    is_prea = 1'b0;
    is_ref  = 1'b0;
    is_uns  = 1'b0;
    if (!cs_q) begin
      case ({ras_q, cas_q, we_q})
        3'b111:  ;
        3'b011:  is_act = 1'b1;
        3'b101:  is_rd  = 1'b1;
        3'b100:  is_wr  = 1'b1;
        3'b001:  is_ref = 1'b1;
        3'b010:  begin
          is_prea = addr_q[10];
          is_pre  = !addr_q[10];
        end
        default: is_uns = 1'b1;
      endcase
    end
    dec_valid = is_act | is_rd | is_wr | is_pre | is_prea | is_ref | is_uns;
    dec_type  = is_act  ? CMD_ACT  :
                is_rd   ? CMD_RD   :
                is_wr   ? CMD_WR   :
                is_pre  ? CMD_PRE  :
                is_prea ? CMD_PREA :
                is_ref  ? CMD_REF  :
                is_uns  ? CMD_UNS  : CMD_ACT;
  end

  // A counter that has reached 0 means the bank has already completed its transition
  always_comb begin
    any_busy = 1'b0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      eff[b] = state_q[b];
      if (state_q[b] == ACTIVATING && cnt_q[b] == '0) eff[b] = ACTIVE;
      if (state_q[b] == PRECHARGING && cnt_q[b] == '0) eff[b] = IDLE;
      if (eff[b] != IDLE) any_busy = 1'b1;
    end
  end

  always_comb begin
    code_d = ERR_NONE;
    if (dec_valid && !cke_q)                          code_d = ERR_CKE_LOW;
    else if (is_uns)                                  code_d = ERR_UNSUP;
    else if (dec_valid && rfc_q != '0)                code_d = ERR_IN_RFC;
    else if (is_act && eff[ba_q] != IDLE)             code_d = ERR_BANK_BUSY;
    else if ((is_rd || is_wr) && eff[ba_q] != ACTIVE) code_d = ERR_NOT_ACTIVE;
    else if (is_ref && any_busy)                      code_d = ERR_REF_IDLE;
    legal = dec_valid && (code_d == ERR_NONE);
  end

  // Next-state: timers always count down; only legal commands move banks or load timers
  always_comb begin
    rfc_d = (rfc_q != '0) ? rfc_q - RFC_W'(1) : rfc_q;
    if (legal && is_ref) rfc_d = RFC_W'(T_RFC - 1);
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      state_d[b] = eff[b];
      cnt_d[b]   = (cnt_q[b] != '0) ? cnt_q[b] - CNT_W'(1) : cnt_q[b];
      if (legal && is_act && ba_q == BA_WIDTH'(b)) begin
        state_d[b] = ACTIVATING;
        cnt_d[b]   = CNT_W'(T_RCD - 1);
      end
      if (legal && (is_prea || (is_pre && ba_q == BA_WIDTH'(b))) &&
          (eff[b] == ACTIVATING || eff[b] == ACTIVE)) begin
        state_d[b] = PRECHARGING;
        cnt_d[b]   = CNT_W'(T_RP - 1);
      end
      open_d[b] = (state_d[b] == ACTIVATING) || (state_d[b] == ACTIVE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= IDLE;
        cnt_q[b]   <= '0;
      end
      rfc_q <= '0;
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      rfc_q <= rfc_d;
    end
  end

  // Stage 2 outputs; bank and address are suppressed for bankless commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid  <= 1'b0;
      cmd_type   <= '0;
      cmd_ba     <= '0;
      cmd_addr   <= '0;
      bank_open  <= '0;
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_sticky <= 1'b0;
    end else begin
      cmd_valid  <= dec_valid;
      cmd_type   <= dec_type;
      cmd_ba     <= (dec_valid && !is_ref && !is_prea) ? ba_q : '0;
      cmd_addr   <= (dec_valid && !is_ref && !is_prea) ? addr_q : '0;
      bank_open  <= open_d;
      err_valid  <= (code_d != ERR_NONE);
      err_code   <= code_d;
      err_sticky <= err_sticky | (code_d != ERR_NONE);
    end
  end

endmodule

// File: tb/tb_sal_dfi_cmd_decoder.sv
// Directed, table-driven bench for sal_dfi_cmd_decoder: each vector is issued a
// given number of cycles after the previous one and its outputs checked two negedges later.
module tb_sal_dfi_cmd_decoder;

  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;
  localparam logic [3:0] C_U6  = 4'b0110;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_DES = 4'b1111;

  logic        clk, rst_n, cke, ras_n, cas_n, we_n;
  logic [0:0]  cs_n;
  logic [2:0]  ba;
  logic [15:0] addr;
  logic        cmd_valid, err_valid, err_sticky;
  logic [2:0]  cmd_type, cmd_ba, err_code;
  logic [15:0] cmd_addr;
  logic [7:0]  bank_open;

  sal_dfi_cmd_decoder dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .bank_open(bank_open), .err_valid(err_valid),
    .err_code(err_code), .err_sticky(err_sticky)
  );

  typedef struct {
    logic        rst;
    int          gap;
    logic        chk;
    logic        cke;
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [15:0] addr;
    logic        e_valid;
    logic [2:0]  e_type;
    logic [2:0]  e_ba;
    logic [15:0] e_addr;
    logic        e_err;
    logic [2:0]  e_code;
    logic [7:0]  e_open;
    logic        e_sticky;
    int          id;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl[$];
  vec_t pipe0, pipe1, nop_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input int gap, input logic k, input logic [3:0] c,
                              input logic [2:0] b, input logic [15:0] a, input logic ev,
                              input logic [2:0] et, input logic [2:0] eb, input logic [15:0] ea,
                              input logic ee, input logic [2:0] ec, input logic [7:0] eo,
                              input logic es);
    vec_t v;
    v.rst = rst; v.gap = gap; v.chk = 1'b1; v.cke = k; v.cmd = c; v.ba = b; v.addr = a;
    v.e_valid = ev; v.e_type = et; v.e_ba = eb; v.e_addr = ea; v.e_err = ee;
    v.e_code = ec; v.e_open = eo; v.e_sticky = es; v.id = -1;
    return v;
  endfunction

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, id, act, exp);
    end
  endtask

  task automatic check(input vec_t v);
    cmp("cmd_valid",  v.id, 32'(cmd_valid),  32'(v.e_valid));
    cmp("cmd_type",   v.id, 32'(cmd_type),   32'(v.e_type));
    cmp("cmd_ba",     v.id, 32'(cmd_ba),     32'(v.e_ba));
    cmp("cmd_addr",   v.id, 32'(cmd_addr),   32'(v.e_addr));
    cmp("err_valid",  v.id, 32'(err_valid),  32'(v.e_err));
    cmp("err_code",   v.id, 32'(err_code),   32'(v.e_code));
    cmp("bank_open",  v.id, 32'(bank_open),  32'(v.e_open));
    cmp("err_sticky", v.id, 32'(err_sticky), 32'(v.e_sticky));
  endtask

  task automatic check_zero(input int id);
    cmp("rst_cmd_valid",  id, 32'(cmd_valid),  32'd0);
    cmp("rst_cmd_type",   id, 32'(cmd_type),   32'd0);
    cmp("rst_cmd_ba",     id, 32'(cmd_ba),     32'd0);
    cmp("rst_cmd_addr",   id, 32'(cmd_addr),   32'd0);
    cmp("rst_bank_open",  id, 32'(bank_open),  32'd0);
    cmp("rst_err_valid",  id, 32'(err_valid),  32'd0);
    cmp("rst_err_code",   id, 32'(err_code),   32'd0);
    cmp("rst_err_sticky", id, 32'(err_sticky), 32'd0);
  endtask

  task automatic drive(input vec_t v);
    cke = v.cke;
    {cs_n[0], ras_n, cas_n, we_n} = v.cmd;
    ba = v.ba;
    addr = v.addr;
  endtask

  // One cycle: check the vector issued two negedges ago, then drive this one
  task automatic tick(input vec_t v);
    @(negedge clk);
    if (pipe1.chk) check(pipe1);
    pipe1 = pipe0;
    pipe0 = v;
    drive(v);
  endtask

  task automatic do_reset(input int id);
    tick(nop_v);
    tick(nop_v);
    @(negedge clk);
    rst_n = 1'b0;
    drive(nop_v);
    pipe0.chk = 1'b0;
    pipe1.chk = 1'b0;
    #1 check_zero(id);
    @(negedge clk);
    check_zero(id);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    nop_v = mk(0, 1, 1, C_NOP, 3'd0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop_v.chk = 1'b0;
    pipe0 = nop_v;
    pipe1 = nop_v;
    drive(mk(0, 1, 1, C_DES, 3'd0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0));

    // rst gap cke cmd ba addr | valid type ba addr err code open sticky
    tbl.push_back(mk(1,  1, 1, C_ACT, 3'd2, 16'h1234, 1, 3'd0, 3'd2, 16'h1234, 0, 3'd0, 8'h04, 0));
    tbl.push_back(mk(0, 10, 1, C_RD,  3'd2, 16'h0040, 1, 3'd1, 3'd2, 16'h0040, 0, 3'd0, 8'h04, 0));
    tbl.push_back(mk(1,  1, 1, C_ACT, 3'd1, 16'h0010, 1, 3'd0, 3'd1, 16'h0010, 0, 3'd0, 8'h02, 0));
    tbl.push_back(mk(0,  9, 1, C_RD,  3'd1, 16'h0020, 1, 3'd1, 3'd1, 16'h0020, 1, 3'd2, 8'h02, 1));
    tbl.push_back(mk(0,  1, 1, C_RD,  3'd1, 16'h0020, 1, 3'd1, 3'd1, 16'h0020, 0, 3'd0, 8'h02, 1));
    tbl.push_back(mk(0,  1, 1, C_WR,  3'd1, 16'h0030, 1, 3'd2, 3'd1, 16'h0030, 0, 3'd0, 8'h02, 1));
    tbl.push_back(mk(1,  1, 1, C_ACT, 3'd3, 16'h0100, 1, 3'd0, 3'd3, 16'h0100, 0, 3'd0, 8'h08, 0));
    tbl.push_back(mk(0, 12, 1, C_PRE, 3'd3, 16'h0000, 1, 3'd3, 3'd3, 16'h0000, 0, 3'd0, 8'h00, 0));
    tbl.push_back(mk(0,  9, 1, C_ACT, 3'd3, 16'h0200, 1, 3'd0, 3'd3, 16'h0200, 1, 3'd1, 8'h00, 1));
    tbl.push_back(mk(0,  1, 1, C_ACT, 3'd3, 16'h0200, 1, 3'd0, 3'd3, 16'h0200, 0, 3'd0, 8'h08, 1));
    tbl.push_back(mk(1,  1, 1, C_ACT, 3'd0, 16'h0011, 1, 3'd0, 3'd0, 16'h0011, 0, 3'd0, 8'h01, 0));
    tbl.push_back(mk(0,  1, 1, C_ACT, 3'd5, 16'h0022, 1, 3'd0, 3'd5, 16'h0022, 0, 3'd0, 8'h21, 0));
    tbl.push_back(mk(0,  1, 1, C_REF, 3'd7, 16'hffff, 1, 3'd5, 3'd0, 16'h0000, 1, 3'd3, 8'h21, 1));
    tbl.push_back(mk(0,  1, 1, C_PRE, 3'd6, 16'h0400, 1, 3'd4, 3'd0, 16'h0000, 0, 3'd0, 8'h00, 1));
    tbl.push_back(mk(0, 10, 1, C_REF, 3'd3, 16'h1111, 1, 3'd5, 3'd0, 16'h0000, 0, 3'd0, 8'h00, 1));
    tbl.push_back(mk(0, 51, 1, C_ACT, 3'd4, 16'h0055, 1, 3'd0, 3'd4, 16'h0055, 1, 3'd4, 8'h00, 1));
    tbl.push_back(mk(0,  1, 1, C_ACT, 3'd4, 16'h0055, 1, 3'd0, 3'd4, 16'h0055, 0, 3'd0, 8'h10, 1));
    tbl.push_back(mk(1,  1, 1, C_MRS, 3'd1, 16'h0abc, 1, 3'd7, 3'd1, 16'h0abc, 1, 3'd5, 8'h00, 1));
    tbl.push_back(mk(0,  1, 1, C_DES, 'x,   'x,       0, 3'd0, 3'd0, 16'h0000, 0, 3'd0, 8'h00, 1));
    tbl.push_back(mk(0,  1, 1, C_U6,  3'd2, 16'h0007, 1, 3'd7, 3'd2, 16'h0007, 1, 3'd5, 8'h00, 1));
    tbl.push_back(mk(0,  1, 0, C_ACT, 3'd2, 16'h0008, 1, 3'd0, 3'd2, 16'h0008, 1, 3'd6, 8'h00, 1));
    tbl.push_back(mk(0,  1, 0, C_MRS, 3'd2, 16'h0009, 1, 3'd7, 3'd2, 16'h0009, 1, 3'd6, 8'h00, 1));
    tbl.push_back(mk(0,  1, 1, C_ACT, 3'd2, 16'h000a, 1, 3'd0, 3'd2, 16'h000a, 0, 3'd0, 8'h04, 1));
    tbl.push_back(mk(0,  1, 1, C_PRE, 3'd6, 16'h0000, 1, 3'd3, 3'd6, 16'h0000, 0, 3'd0, 8'h04, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      v.id = i;
      if (v.rst) do_reset(i);
      repeat (v.gap - 1) tick(nop_v);
      tick(v);
    end

    // Reset in the middle of an activation must drop all bank state at once
    do_reset(100);
    v = mk(0, 1, 1, C_ACT, 3'd0, 16'h0077, 1, 3'd0, 3'd0, 16'h0077, 0, 3'd0, 8'h01, 0);
    v.id = 101;
    tick(v);
    tick(nop_v);
    tick(nop_v);
    @(negedge clk);
    rst_n = 1'b0;
    drive(nop_v);
    pipe0.chk = 1'b0;
    pipe1.chk = 1'b0;
    #1 check_zero(102);
    @(negedge clk);
    check_zero(103);
    rst_n = 1'b1;
    v.id = 104;
    tick(v);
    tick(nop_v);
    tick(nop_v);
    tick(nop_v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
